// File: rtl/boot_pkg.sv
// Shared encodings and default parameters for the reset/boot/halt controller.
package boot_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2
  } boot_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_DEBUG  = 2'd2,
    CAUSE_WDT    = 2'd3
  } reset_cause_t;

  localparam int DEF_PRESCALE     = 256;
  localparam int DEF_DEBOUNCE     = 10;
  localparam int DEF_LONG_PRESS   = 1023;
  localparam int DEF_RESET_CYCLES = 250;
  localparam int DEF_BOOT_CYCLES  = 10;

  // Simultaneous requests resolve button > debug > watchdog.
  function automatic reset_cause_t pick_cause(input logic btn_req, input logic dbg_req);
    return btn_req ? CAUSE_BUTTON : (dbg_req ? CAUSE_DEBUG : CAUSE_WDT);
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Request inputs and core control outputs of the boot sequencer.
interface boot_sequencer_if;
  import boot_pkg::*;

  logic         button;
  logic         dbg_reset_req;
  logic         dbg_halt_req;
  logic         dbg_run_req;
  logic         wdt_expire;
  logic         cpu_reset;
  logic         cpu_boot;
  logic         cpu_halt;
  logic         cpu_interrupt;
  boot_state_t  state;
  reset_cause_t reset_cause;

  modport master (
    input  button, dbg_reset_req, dbg_halt_req, dbg_run_req, wdt_expire,
    output cpu_reset, cpu_boot, cpu_halt, cpu_interrupt, state, reset_cause
  );

  modport slave (
    output button, dbg_reset_req, dbg_halt_req, dbg_run_req, wdt_expire,
    input  cpu_reset, cpu_boot, cpu_halt, cpu_interrupt, state, reset_cause
  );

endinterface

// File: rtl/boot_sequencer_button_debounce.sv
// Button synchronizer, slow-tick debounce and short/long press classification.
// Outputs are single-cycle registered pulses; no backpressure.
module button_debounce #(
  parameter int PRESCALE   = 256,
  parameter int DEBOUNCE   = 10,
  parameter int LONG_PRESS = 1023
) (
  input  logic sysclk,
  input  logic reset,
  input  logic button,
  output logic btn_reset_req,
  output logic btn_short_release
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = $clog2(LONG_PRESS + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [PW-1:0] pscale;
  logic [DW-1:0] stab;
  logic [LW-1:0] press;
  logic          tick;
  logic          flip;

  assign tick = (pscale == PW'(PRESCALE - 1));
  assign flip = (sync2 != level) && (stab == DW'(DEBOUNCE - 1));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1             <= 1'b0;
      sync2             <= 1'b0;
      level             <= 1'b0;
      pscale            <= '0;
      stab              <= '0;
      press             <= '0;
      btn_reset_req     <= 1'b0;
      btn_short_release <= 1'b0;
    end else begin
      sync1             <= button;
      sync2             <= sync1;
      pscale            <= tick ? '0 : pscale + 1'b1;
      btn_reset_req     <= 1'b0;
      btn_short_release <= 1'b0;
      if (tick) begin
        if (sync2 == level) begin
          stab <= '0;
        end else if (flip) begin
          level <= ~level;
          stab  <= '0;
        end else begin
          stab <= stab + 1'b1;
        end
        // A saturated counter marks a press already consumed as a reset.
        if (level && flip) begin
          press             <= '0;
          btn_short_release <= (press != LW'(LONG_PRESS));
        end else if (level && (press != LW'(LONG_PRESS))) begin
          press         <= press + 1'b1;
          btn_reset_req <= (press == LW'(LONG_PRESS - 1));
        end
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Reset/boot/halt controller: arbitrates button, debug and watchdog requests.
// All outputs registered, one cycle from request; no backpressure.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int LONG_PRESS   = DEF_LONG_PRESS,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic              sysclk,
  input  logic              reset,
  boot_sequencer_if.master  bus
);

  localparam int HW = $clog2(RESET_CYCLES);

  logic          btn_reset_req;
  logic          btn_short_release;
  logic          any_reset;
  boot_state_t   state_q;
  reset_cause_t  cause_q;
  logic [HW-1:0] hold_cnt;
  logic          reset_q;
  logic          boot_q;
  logic          halt_q;
  logic          irq_q;

  button_debounce #(
    .PRESCALE   (PRESCALE),
    .DEBOUNCE   (DEBOUNCE),
    .LONG_PRESS (LONG_PRESS)
  ) u_button (
    .sysclk            (sysclk),
    .reset             (reset),
    .button            (bus.button),
    .btn_reset_req     (btn_reset_req),
    .btn_short_release (btn_short_release)
  );

  assign any_reset = btn_reset_req | bus.dbg_reset_req | bus.wdt_expire;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= RESET_HOLD;
      cause_q  <= CAUSE_POR;
      hold_cnt <= '0;
      reset_q  <= 1'b1;
      boot_q   <= 1'b0;
      halt_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (any_reset) begin
        // Re-entry from RESET_HOLD also restarts the full hold window.
        state_q  <= RESET_HOLD;
        cause_q  <= pick_cause(btn_reset_req, bus.dbg_reset_req);
        hold_cnt <= '0;
        reset_q  <= 1'b1;
        boot_q   <= 1'b0;
        halt_q   <= 1'b0;
      end else begin
        case (state_q)
          RESET_HOLD: begin
            if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
              state_q <= RUN;
              reset_q <= 1'b0;
              boot_q  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
              boot_q   <= (int'(hold_cnt) + 1 >= RESET_CYCLES - BOOT_CYCLES);
            end
          end
          RUN: begin
            irq_q <= btn_short_release;
            if (bus.dbg_halt_req) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end
          end
          HALTED: begin
            if (bus.dbg_run_req && !bus.dbg_halt_req) begin
              state_q <= RUN;
              halt_q  <= 1'b0;
            end
          end
          default: state_q <= RESET_HOLD;
        endcase
      end
    end
  end

  assign bus.state         = state_q;
  assign bus.reset_cause   = cause_q;
  assign bus.cpu_reset     = reset_q;
  assign bus.cpu_boot      = boot_q;
  assign bus.cpu_halt      = halt_q;
  assign bus.cpu_interrupt = irq_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed and randomized bench for boot_sequencer against a per-edge reference model.
module tb_boot_sequencer;
  import boot_pkg::*;

  localparam int P = 4;
  localparam int D = 3;
  localparam int L = 8;
  localparam int R = 20;
  localparam int B = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  boot_sequencer_if bus();

  boot_sequencer #(
    .PRESCALE(P), .DEBOUNCE(D), .LONG_PRESS(L), .RESET_CYCLES(R), .BOOT_CYCLES(B)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the FSM counts down the remaining hold cycles; the
  // button path is a two-edge delay followed by per-tick run-length rules.
  int m_state;      // 0 hold, 1 run, 2 halted
  int m_hold_left;
  int m_cause;
  int m_edge;
  int m_lvl;
  int m_run;
  int m_press;
  bit m_breq;
  bit m_short;
  bit m_intr;
  bit btn_q[$];

  function automatic void m_reset();
    m_state = 0; m_hold_left = R; m_cause = 0; m_edge = 0;
    m_lvl = 0; m_run = 0; m_press = 0;
    m_breq = 0; m_short = 0; m_intr = 0;
    btn_q.delete();
    btn_q.push_back(1'b0);
    btn_q.push_back(1'b0);
  endfunction

  function automatic void m_step();
    bit any;
    int sample;
    int was;
    bit released;
    any = m_breq || bus.dbg_reset_req || bus.wdt_expire;
    m_intr = 0;
    if (any) begin
      m_cause = m_breq ? 1 : (bus.dbg_reset_req ? 2 : 3);
      m_state = 0;
      m_hold_left = R;
    end else if (m_state == 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_state = 1;
    end else if (m_state == 1) begin
      m_intr = m_short;
      if (bus.dbg_halt_req) m_state = 2;
    end else if (bus.dbg_run_req && !bus.dbg_halt_req) begin
      m_state = 1;
    end

    m_edge++;
    sample = btn_q[0];
    void'(btn_q.pop_front());
    btn_q.push_back(bus.button);
    m_breq  = 0;
    m_short = 0;
    if (m_edge % P == 0) begin
      was = m_lvl;
      released = 0;
      if (sample == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_run = 0;
          released = (m_lvl == 1);
          m_lvl = 1 - m_lvl;
        end
      end
      if (released) begin
        m_short = (m_press < L);
        m_press = 0;
      end else if (was == 1 && m_press < L) begin
        m_press++;
        m_breq = (m_press == L);
      end
    end
  endfunction

  function automatic logic [7:0] m_out();
    return {m_state == 0, (m_state == 0) && (m_hold_left <= B), m_state == 2, m_intr,
            2'(m_state), 2'(m_cause)};
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.cpu_reset, bus.cpu_boot, bus.cpu_halt, bus.cpu_interrupt,
            2'(bus.state), 2'(bus.reset_cause)};
  endfunction

  int irq_cnt;
  int rst_entries;
  bit prev_rst;

  task automatic clear_counts();
    irq_cnt = 0; rst_entries = 0; prev_rst = bus.cpu_reset;
  endtask

  task automatic cyc();
    @(posedge sysclk);
    m_step();
    #1;
    chk("outputs", dut_out(), m_out());
    irq_cnt += int'(bus.cpu_interrupt);
    if (bus.cpu_reset && !prev_rst) rst_entries++;
    prev_rst = bus.cpu_reset;
  endtask

  task automatic idle_inputs();
    bus.button = 0; bus.dbg_reset_req = 0; bus.dbg_halt_req = 0;
    bus.dbg_run_req = 0; bus.wdt_expire = 0;
  endtask

  initial begin
    int n;
    int w;
    int btn_left;
    idle_inputs();

    // Power-on
    #1 reset = 1'b1;
    #1 chk("reset_state", dut_out(), 8'h80);
    m_reset();
    #1 reset = 1'b0;
    for (int i = 1; i <= R; i++) begin
      cyc();
      if (i == 15) chk("boot_before", bus.cpu_boot, 1'b0);
      if (i == 16) chk("boot_start", bus.cpu_boot, 1'b1);
      if (i == 19) chk("reset_last", {bus.cpu_reset, bus.cpu_boot}, 2'b11);
    end
    chk("por_run", {bus.cpu_reset, bus.cpu_boot, 2'(bus.state)}, 4'b0001);
    chk("por_cause", bus.reset_cause, 0);

    // Short press, then a glitch
    clear_counts();
    bus.button = 1; repeat (20) cyc();
    bus.button = 0; repeat (40) cyc();
    chk("short_irq", irq_cnt, 1);
    chk("short_no_reset", rst_entries, 0);
    clear_counts();
    bus.button = 1; repeat (6) cyc();
    bus.button = 0; repeat (30) cyc();
    chk("glitch_irq", irq_cnt, 0);

    // Long press held well past the threshold
    clear_counts();
    bus.button = 1; repeat (100) cyc();
    chk("long_one_reset", rst_entries, 1);
    chk("long_cause", bus.reset_cause, 1);
    bus.button = 0; repeat (40) cyc();
    chk("long_no_irq", irq_cnt, 0);
    chk("long_run", bus.state, RUN);

    // Halt / resume
    bus.dbg_halt_req = 1; cyc();
    chk("halt_next", {bus.cpu_halt, 2'(bus.state)}, 3'b110);
    bus.dbg_run_req = 1; cyc();
    chk("run_and_halt", bus.state, HALTED);
    bus.dbg_halt_req = 0; bus.dbg_run_req = 0; cyc();
    chk("halt_hold", bus.state, HALTED);
    bus.dbg_run_req = 1; cyc(); bus.dbg_run_req = 0;
    chk("resume", {bus.cpu_halt, 2'(bus.state)}, 3'b001);

    // Reset request in the middle of the hold window
    bus.dbg_reset_req = 1; cyc(); bus.dbg_reset_req = 0;
    repeat (10) cyc();
    chk("midhold_in_hold", {bus.cpu_reset, bus.cpu_boot}, 2'b10);
    n = 0;
    bus.dbg_reset_req = 1; cyc(); bus.dbg_reset_req = 0;
    n += int'(bus.cpu_reset);
    repeat (24) begin cyc(); n += int'(bus.cpu_reset); end
    chk("midhold_len", n, R);
    chk("midhold_cause", bus.reset_cause, 2);

    // Simultaneous debug + watchdog
    bus.wdt_expire = 1; bus.dbg_reset_req = 1; cyc();
    bus.wdt_expire = 0; bus.dbg_reset_req = 0;
    chk("simul_cause", {bus.cpu_reset, 2'(bus.reset_cause)}, 3'b110);
    repeat (25) cyc();

    // Randomized traffic
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        bus.button = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 70);
      end
      btn_left--;
      if ($urandom_range(0, 39) == 0) bus.dbg_halt_req = ~bus.dbg_halt_req;
      bus.dbg_run_req   = ($urandom_range(0, 9) == 0);
      bus.dbg_reset_req = ($urandom_range(0, 249) == 0);
      bus.wdt_expire    = ($urandom_range(0, 299) == 0);
      cyc();
    end
    idle_inputs();

    // Asynchronous reset mid-RUN, no clock edge needed
    w = 0;
    while (bus.state != RUN && w < 100) begin cyc(); w++; end
    chk("reach_run", bus.state, RUN);
    #2 reset = 1'b1;
    #1 chk("async_reset", dut_out(), 8'h80);
    m_reset();
    #2 reset = 1'b0;
    repeat (25) cyc();
    chk("after_async", {2'(bus.state), 2'(bus.reset_cause)}, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Central reset/boot/halt controller for the CPU core.
- Sequences power-on and requested resets, generates the boot strobe, and arbitrates reset and halt requests from three sources: front-panel button, debug host and watchdog.
- Debounces the button: short press gives an interrupt pulse; long press gives a full reset.
- All outputs are registered and drive the core's reset/boot/halt/interrupt inputs directly.

Parameters:
- PRESCALE, 256: sysclk cycles per slow sample tick (button sampling). Must be ≥2.
- DEBOUNCE, 10: consecutive identical slow-tick samples required to change the debounced button level.
- LONG_PRESS, 1023: slow ticks of continuous debounced press that constitute a reset request.
- RESET_CYCLES, 250: sysclk cycles spent in RESET_HOLD.
- BOOT_CYCLES, 10: final cycles of RESET_HOLD during which cpu_boot is high. Must be < RESET_CYCLES.

Ports:
- sysclk, in, 1: system clock.
- reset, in, 1: asynchronous active-high reset.
- button, in, 1: raw asynchronous front-panel button, high = pressed.
- dbg_reset_req, in, 1: single-cycle debug reset request.
- dbg_halt_req, in, 1: level; halt the core while high.
- dbg_run_req, in, 1: single-cycle resume request.
- wdt_expire, in, 1: single-cycle watchdog expiry.
- cpu_reset, out, 1: core reset.
- cpu_boot, out, 1: boot strap strobe.
- cpu_halt, out, 1: core halt.
- cpu_interrupt, out, 1: one-cycle interrupt pulse.
- state, out, 2: 0 RESET_HOLD, 1 RUN, 2 HALTED.
- reset_cause, out, 2: 0 power-on, 1 button, 2 debug, 3 watchdog.

Behaviour:
- **Clock and reset.** One clock (sysclk); reset is asynchronous and active-high. Asserting reset forces:
  - state=RESET_HOLD, hold counter=0, cpu_reset=1, cpu_boot=0, cpu_halt=0, cpu_interrupt=0;
  - reset_cause=0, debounce/press counters=0, debounced level=0, prescaler=0.
- **Button front end.**
  - 2-flop synchronizer on button.
  - Prescaler wraps modulo PRESCALE and produces a tick on count PRESCALE-1.
  - On each tick, the synchronized sample is compared with the debounced level:
    - if equal, the stability counter clears;
    - otherwise it increments, and on reaching DEBOUNCE the debounced level flips and the counter clears.
- **Press classification.**
  - While the debounced level is pressed, a press counter increments per tick and saturates at LONG_PRESS.
  - Reaching LONG_PRESS raises btn_reset_req for one sysclk cycle. The counter then stays saturated, so only one request is issued per press.
  - Debounced release with the press counter < LONG_PRESS pulses cpu_interrupt for exactly one cycle, but only if state=RUN. The pulse is dropped otherwise.
  - Release clears the press counter.
- **Reset request.** any_reset = btn_reset_req | dbg_reset_req | wdt_expire. Cause priority when simultaneous: button > debug > watchdog.
- **FSM, evaluated every sysclk.**
  - Any state with any_reset=1: go to RESET_HOLD, hold counter=0, reset_cause latched. This includes RESET_HOLD itself, which restarts the full RESET_CYCLES.
  - RESET_HOLD:
    - cpu_reset=1; cpu_boot=1 while counter ≥ RESET_CYCLES-BOOT_CYCLES.
    - The counter increments each cycle.
    - At counter=RESET_CYCLES-1 the FSM goes to RUN: cpu_reset and cpu_boot fall together on the transition cycle edge.
  - RUN: cpu_reset=0, cpu_halt=0. dbg_halt_req=1 goes to HALTED, and cpu_halt=1 on the next cycle.
  - HALTED: cpu_halt=1. dbg_run_req=1 with dbg_halt_req=0 goes to RUN. If both are high, halt wins and the FSM stays in HALTED.
  - dbg_halt_req during RESET_HOLD is ignored until RUN is reached; it then takes effect one cycle later.
- **Latency.** Request to output is 1 cycle for all of them. The state output equals the registered FSM state.
- **Width rules.** The hold counter is $clog2(RESET_CYCLES) bits. The press counter is $clog2(LONG_PRESS+1) bits and saturating. No counter wraps except the prescaler.

Decomposition:
- Shared package boot_pkg holds:
  - the state encodings (RESET_HOLD=0, RUN=1, HALTED=2);
  - the reset_cause encodings;
  - the default parameter constants.
- One sub-module, button_debounce: synchronizer, prescaler, debounce and press classification. Outputs btn_reset_req and btn_short_release.
- The FSM and output registers stay in boot_sequencer.

Test Plan (PRESCALE=4, DEBOUNCE=3, LONG_PRESS=8, RESET_CYCLES=20, BOOT_CYCLES=4):
- **Power-on:** release reset at t0 → cpu_reset=1 for 20 cycles; cpu_boot=1 on cycles 16–19; both 0 and state=1 from cycle 20; reset_cause=0.
- **Short press:** button high for 20 sysclk then low, in RUN → exactly one cpu_interrupt pulse after debounced release; no reset; cpu_interrupt never asserted for a 6-cycle glitch.
- **Long press:** button held 60 sysclk in RUN → one RESET_HOLD entry with reset_cause=1; no interrupt on release; holding longer gives no second reset.
- **Halt/resume:** dbg_halt_req high in RUN → cpu_halt=1 next cycle, state=2; run+halt together → stays halted; halt low then dbg_run_req → state=1, cpu_halt=0 next cycle.
- **Reset mid-hold:** dbg_reset_req at hold count 10 → count restarts, cpu_reset stays 1 for another 20 cycles, reset_cause=2.
- **Simultaneous requests:** wdt_expire with dbg_reset_req in the same cycle → reset_cause=2. Async reset asserted mid-RUN → all outputs at reset values with no clock edge needed.
